// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller for the 5-stage RV32I core.
// Handles operand forwarding into Execute, load-use bubbles with a configurable
// load latency, multi-cycle MDU stalls and data-memory wait freezes.
// Optional feature: define HAZARD_PERF_CNT_EN to build the saturating
// stall/flush performance counters; otherwise both counter outputs read 0.
module hazard_ctrl_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int LOAD_LAT   = 1,
  parameter int CNT_W      = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [REG_ADDR_W-1:0] rs1_addr_d_i,
  input  logic [REG_ADDR_W-1:0] rs2_addr_d_i,
  input  logic                  rs1_used_d_i,
  input  logic                  rs2_used_d_i,
  input  logic [REG_ADDR_W-1:0] rs1_addr_e_i,
  input  logic [REG_ADDR_W-1:0] rs2_addr_e_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_e_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_m_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_w_i,
  input  logic                  load_e_i,
  input  logic                  reg_wr_en_m_i,
  input  logic                  reg_wr_en_w_i,
  input  logic                  pc_src_e_i,
  input  logic                  mdu_start_e_i,
  input  logic                  mdu_done_i,
  input  logic                  mem_busy_i,
  output logic [1:0]            forward_a_e_o,
  output logic [1:0]            forward_b_e_o,
  output logic                  stall_f_o,
  output logic                  stall_d_o,
  output logic                  stall_e_o,
  output logic                  stall_m_o,
  output logic                  stall_w_o,
  output logic                  flush_d_o,
  output logic                  flush_e_o,
  output logic                  flush_m_o,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MDU_WAIT = 2'd2
  } state_t;

  // Bubbles still owed after the first one; LOAD_LAT is at most 4, so 2 bits suffice.
  localparam logic [1:0] BUB_INIT = 2'(LOAD_LAT - 1);

  state_t     state;
  logic [1:0] bub_cnt;
  logic       lu_hit;

  // Forward select for one Execute operand; the younger M result wins over W.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0] src,
    input logic [REG_ADDR_W-1:0] rd_m,
    input logic                  wen_m,
    input logic [REG_ADDR_W-1:0] rd_w,
    input logic                  wen_w
  );
    if (wen_m && (rd_m != '0) && (rd_m == src))
      return 2'b10;
    else if (wen_w && (rd_w != '0) && (rd_w == src))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  // Forwarding muxes stay live even while the pipeline is frozen.
  always_comb begin
    forward_a_e_o = fwd_sel(rs1_addr_e_i, rd_addr_m_i, reg_wr_en_m_i, rd_addr_w_i, reg_wr_en_w_i);
    forward_b_e_o = fwd_sel(rs2_addr_e_i, rd_addr_m_i, reg_wr_en_m_i, rd_addr_w_i, reg_wr_en_w_i);
  end

  // A load in Execute whose destination is read by the instruction in Decode.
  always_comb begin
    lu_hit = load_e_i && (rd_addr_e_i != '0) &&
             ((rs1_used_d_i && (rd_addr_e_i == rs1_addr_d_i)) ||
              (rs2_used_d_i && (rd_addr_e_i == rs2_addr_d_i)));
  end

  // Stall/flush decode: freeze overrides everything, then redirect, MDU, load-use.
  // The MDU issue cycle already stalls so the op stays in Execute until done.
  always_comb begin
    stall_f_o = 1'b0;
    stall_d_o = 1'b0;
    stall_e_o = 1'b0;
    stall_m_o = 1'b0;
    stall_w_o = 1'b0;
    flush_d_o = 1'b0;
    flush_e_o = 1'b0;
    flush_m_o = 1'b0;
    if (mem_busy_i) begin
      stall_f_o = 1'b1;
      stall_d_o = 1'b1;
      stall_e_o = 1'b1;
      stall_m_o = 1'b1;
      stall_w_o = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (pc_src_e_i) begin
            flush_d_o = 1'b1;
            flush_e_o = 1'b1;
          end else if (mdu_start_e_i) begin
            stall_f_o = 1'b1;
            stall_d_o = 1'b1;
            stall_e_o = 1'b1;
            flush_m_o = 1'b1;
          end else if (lu_hit) begin
            stall_f_o = 1'b1;
            stall_d_o = 1'b1;
            flush_e_o = 1'b1;
          end
        end
        LU_STALL: begin
          stall_f_o = 1'b1;
          stall_d_o = 1'b1;
          flush_e_o = 1'b1;
        end
        MDU_WAIT: begin
          if (!mdu_done_i) begin
            stall_f_o = 1'b1;
            stall_d_o = 1'b1;
            stall_e_o = 1'b1;
            flush_m_o = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Hazard FSM and bubble counter; both hold while memory is busy.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= RUN;
      bub_cnt <= 2'd0;
    end else if (!mem_busy_i) begin
      case (state)
        RUN: begin
          if (pc_src_e_i) begin
            state <= RUN;
          end else if (mdu_start_e_i) begin
            state <= MDU_WAIT;
          end else if (lu_hit && (LOAD_LAT > 1)) begin
            state   <= LU_STALL;
            bub_cnt <= BUB_INIT;
          end
        end
        LU_STALL: begin
          bub_cnt <= bub_cnt - 2'd1;
          if (bub_cnt <= 2'd1)
            state <= RUN;
        end
        MDU_WAIT: begin
          if (mdu_done_i)
            state <= RUN;
        end
        default: begin
          state   <= RUN;
          bub_cnt <= 2'd0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Saturating event counters; frozen cycles are not counted.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (!mem_busy_i) begin
      if (stall_f_o && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_d_o && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt_o = stall_cnt;
  assign flush_cnt_o = flush_cnt;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule
